// File: rtl/vla_mem_responder.sv
// Memory-side responder for the VLA CPU bus: strobe-protocol checked reads/writes.
// Optional MEM_PROT_EN: suppress commits below PROT_BASE and flag them as errors.
module vla_mem_responder #(
    parameter int AWIDTH    = 5,
    parameter int DWIDTH    = 8,
    parameter int PROT_BASE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] addr,
    input  logic              rd,
    input  logic              data_e,
    input  logic              wr,
    input  logic [DWIDTH-1:0] data_in,
    input  logic              err_clr,
    output logic [DWIDTH-1:0] data_out,
    output logic              data_valid,
    output logic              wr_done,
    output logic              wr_err
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WARM,
        WR
    } state_t;

`ifdef MEM_PROT_EN
    localparam bit PROT_ON = 1'b1;
`else
    localparam bit PROT_ON = 1'b0;
`endif

    localparam logic [AWIDTH:0] PBASE = (AWIDTH+1)'(PROT_BASE);

    state_t state, state_n;

    logic [DWIDTH-1:0] mem [2**AWIDTH];

    logic wr_hold;
    logic viol;
    logic commit;
    logic attempt;
    logic rd_load;
    logic valid_n;
    logic prot_ok;

    assign prot_ok = !PROT_ON || ({1'b0, addr} >= PBASE);

    always_comb begin
        state_n = state;
        viol    = 1'b0;
        commit  = 1'b0;
        attempt = 1'b0;
        rd_load = 1'b0;
        valid_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (rd && (wr || data_e)) begin
                    viol = 1'b1;
                end else if (rd) begin
                    state_n = RD;
                end else if (data_e) begin
                    state_n = WARM;
                end else if (wr && !wr_hold) begin
                    viol = 1'b1;
                end
            end
            RD: begin
                if (wr || data_e) begin
                    viol    = 1'b1;
                    state_n = IDLE;
                end else if (rd) begin
                    rd_load = 1'b1;
                    valid_n = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            WARM: begin
                if (rd) begin
                    viol    = 1'b1;
                    state_n = IDLE;
                end else if (wr && data_e && !wr_hold) begin
                    attempt = 1'b1;
                    if (prot_ok) begin
                        commit  = 1'b1;
                        state_n = WR;
                    end else begin
                        viol    = 1'b1;
                        state_n = IDLE;
                    end
                end else if (!data_e) begin
                    // wr without data_e breaks the ordering rule
                    viol    = wr && !wr_hold;
                    state_n = IDLE;
                end
            end
            WR: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            data_out   <= '0;
            data_valid <= 1'b0;
            wr_done    <= 1'b0;
            wr_err     <= 1'b0;
            wr_hold    <= 1'b0;
        end else begin
            state      <= state_n;
            data_valid <= valid_n;
            wr_done    <= commit;
            // a held wr after a commit attempt is ignored until released
            wr_hold    <= wr && (wr_hold || attempt);
            if (rd_load) begin
                data_out <= mem[addr];
            end
            if (viol) begin
                wr_err <= 1'b1;
            end else if (err_clr) begin
                wr_err <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit && !rst) begin
            mem[addr] <= data_in;
        end
    end

endmodule

// File: tb/tb_vla_mem_responder.sv
// Directed plus randomized bench for vla_mem_responder against a memory model.
module tb_vla_mem_responder;

`ifdef MEM_PROT_EN
    localparam int PB = 16;
`else
    localparam int PB = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] addr;
    logic       rd;
    logic       data_e;
    logic       wr;
    logic [7:0] data_in;
    logic       err_clr;
    logic [7:0] data_out;
    logic       data_valid;
    logic       wr_done;
    logic       wr_err;

    logic [7:0] mm [32];
    int checks = 0;
    int errors = 0;

    vla_mem_responder #(
        .AWIDTH(5),
        .DWIDTH(8),
        .PROT_BASE(PB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .addr(addr),
        .rd(rd),
        .data_e(data_e),
        .wr(wr),
        .data_in(data_in),
        .err_clr(err_clr),
        .data_out(data_out),
        .data_valid(data_valid),
        .wr_done(wr_done),
        .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        rd      = 1'b0;
        data_e  = 1'b0;
        wr      = 1'b0;
        err_clr = 1'b0;
    endtask

    function automatic logic [4:0] raddr();
        return 5'(PB + $urandom_range(31 - PB, 0));
    endfunction

    task automatic do_write(input logic [4:0] a, input logic [7:0] d);
        quiet();
        addr   = a;
        data_e = 1'b1;
        step();
        chk("warm_no_done", 32'(wr_done), 32'd0);
        wr      = 1'b1;
        data_in = d;
        step();
        chk("wr_done_pulse", 32'(wr_done), 32'd1);
        mm[a] = d;
        quiet();
        step();
        chk("wr_done_end", 32'(wr_done), 32'd0);
        chk("wr_no_err", 32'(wr_err), 32'd0);
    endtask

    task automatic do_read(input logic [4:0] a, input int n,
                           input bit rnd);
        logic [4:0] cur;
        quiet();
        cur  = a;
        addr = a;
        rd   = 1'b1;
        step();
        chk("rd_entry_valid", 32'(data_valid), 32'd0);
        for (int i = 0; i < n; i++) begin
            if (rnd && i > 0) cur = raddr();
            addr = cur;
            step();
            chk("rd_valid", 32'(data_valid), 32'd1);
            chk("rd_data", 32'(data_out), 32'(mm[cur]));
        end
        rd = 1'b0;
        step();
        chk("rd_end_valid", 32'(data_valid), 32'd0);
        chk("rd_hold_data", 32'(data_out), 32'(mm[cur]));
    endtask

    initial begin
        logic [4:0] a;
        logic [7:0] d;
        quiet();
        rst     = 1'b1;
        addr    = '0;
        data_in = '0;
        step();
        step();
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_wr_done", 32'(wr_done), 32'd0);
        chk("rst_wr_err", 32'(wr_err), 32'd0);
        rst = 1'b0;
        step();

        for (int i = PB; i < 32; i++) do_write(5'(i), 8'($urandom));

        // preload and stream a fixed address
        do_write(5'(PB + 3), 8'hA5);
        do_read(5'(PB + 3), 3, 1'b0);

        do_write(5'(PB + 5), 8'h3C);
        do_read(5'(PB + 5), 1, 1'b0);

        // wr without data_e
        a       = 5'(PB + 7);
        addr    = a;
        wr      = 1'b1;
        data_in = ~mm[a];
        step();
        chk("wr_only_err", 32'(wr_err), 32'd1);
        chk("wr_only_done", 32'(wr_done), 32'd0);
        wr      = 1'b0;
        err_clr = 1'b1;
        step();
        chk("err_clr", 32'(wr_err), 32'd0);
        do_read(a, 1, 1'b0);

        // rd and data_e together from idle
        addr   = 5'(PB + 2);
        rd     = 1'b1;
        data_e = 1'b1;
        step();
        chk("rd_de_err", 32'(wr_err), 32'd1);
        chk("rd_de_valid", 32'(data_valid), 32'd0);
        quiet();
        step();
        chk("rd_de_valid2", 32'(data_valid), 32'd0);
        chk("rd_de_done", 32'(wr_done), 32'd0);

        // violation beats err_clr on the same edge
        wr      = 1'b1;
        err_clr = 1'b1;
        step();
        chk("clr_vs_viol", 32'(wr_err), 32'd1);
        wr = 1'b0;
        step();
        chk("clr_after", 32'(wr_err), 32'd0);
        quiet();

        // wr held after a commit writes once
        a      = 5'(PB + 9);
        d      = 8'h6E;
        addr   = a;
        data_e = 1'b1;
        step();
        wr      = 1'b1;
        data_in = d;
        step();
        chk("held_pulse", 32'(wr_done), 32'd1);
        mm[a]   = d;
        data_e  = 1'b0;
        data_in = ~d;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("held_no_done", 32'(wr_done), 32'd0);
            chk("held_no_err", 32'(wr_err), 32'd0);
        end
        quiet();
        step();
        do_read(a, 1, 1'b0);

        // write strobe arriving during a read burst
        addr = 5'(PB + 1);
        rd   = 1'b1;
        step();
        step();
        chk("rdv_valid", 32'(data_valid), 32'd1);
        data_e = 1'b1;
        step();
        chk("rdv_err", 32'(wr_err), 32'd1);
        chk("rdv_valid_drop", 32'(data_valid), 32'd0);
        quiet();
        err_clr = 1'b1;
        step();
        chk("rdv_clr", 32'(wr_err), 32'd0);
        quiet();

        // data_e abandoned without wr
        a       = 5'(PB + 11);
        addr    = a;
        data_in = ~mm[a];
        data_e  = 1'b1;
        step();
        data_e = 1'b0;
        step();
        chk("abandon_done", 32'(wr_done), 32'd0);
        chk("abandon_err", 32'(wr_err), 32'd0);
        do_read(a, 1, 1'b0);

        // reset while a write is pending
        a       = 5'(PB + 13);
        addr    = a;
        data_in = ~mm[a];
        data_e  = 1'b1;
        step();
        rst = 1'b1;
        wr  = 1'b1;
        step();
        chk("rst_mid_done", 32'(wr_done), 32'd0);
        chk("rst_mid_data", 32'(data_out), 32'd0);
        chk("rst_mid_err", 32'(wr_err), 32'd0);
        rst = 1'b0;
        quiet();
        step();
        do_read(a, 1, 1'b0);

`ifdef MEM_PROT_EN
        addr   = 5'd4;
        data_e = 1'b1;
        step();
        wr = 1'b1;
        step();
        chk("prot_no_done", 32'(wr_done), 32'd0);
        chk("prot_err", 32'(wr_err), 32'd1);
        quiet();
        err_clr = 1'b1;
        step();
        chk("prot_clr", 32'(wr_err), 32'd0);
        quiet();
        do_write(5'd20, 8'h5A);
        do_read(5'd20, 1, 1'b0);
`endif

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(1, 0) == 1)
                do_write(raddr(), 8'($urandom));
            else
                do_read(raddr(), int'($urandom_range(4, 1)), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
